// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester bundle, FIFO write port and debug outputs of the write arbiter.
// master = requesters/FIFO side, slave = the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [31:0]           wr_count;

    modport master (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, winc, wdata, gnt, busy, wr_count
    );
    modport slave (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, winc, wdata, gnt, busy, wr_count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of the async FIFO write port.
// One cycle of arbitration in IDLE, then up to BURST words from the granted requester.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input logic              wclk,
    input logic              wrst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]      state;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   last_gnt;
    logic [IW-1:0]   g;
    logic [IW-1:0]   pick;
    logic [7:0]      burst_cnt;
    logic [31:0]     wr_cnt;
    logic [31:0]     cnt_nxt;
    logic            xfer;
    logic            release_gnt;

    // Descending scan: the last hit is the nearest valid requester after last_gnt.
    always_comb begin
        g    = '0;
        pick = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt_q[i]) g = IW'(i);
        for (int k = NREQ; k >= 1; k--)
            if (bus.req_valid[(int'(last_gnt) + k) % NREQ]) pick = IW'((int'(last_gnt) + k) % NREQ);
    end

    assign xfer        = wrst_n && state == GRANT && bus.req_valid[g] && !bus.wfull;
    assign release_gnt = (xfer && (bus.req_last[g] || burst_cnt == 8'(BURST - 1))) || !bus.req_valid[g];
    assign cnt_nxt     = wr_cnt + 32'(xfer);

    assign bus.req_ready = xfer ? NREQ'(1) << g : '0;
    assign bus.winc      = xfer;
    assign bus.wdata     = |gnt_q ? bus.req_data[g*DSIZE +: DSIZE] : '0;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = state == GRANT;
    assign bus.wr_count  = wr_cnt;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state     <= IDLE;
            gnt_q     <= '0;
            burst_cnt <= '0;
            wr_cnt    <= '0;
            last_gnt  <= IW'(NREQ - 1);
        end else begin
            wr_cnt <= cnt_nxt;
            if (state == IDLE) begin
                if (|bus.req_valid) begin
                    state     <= GRANT;
                    gnt_q     <= NREQ'(1) << pick;
                    burst_cnt <= '0;
                end
            end else begin
                if (xfer) burst_cnt <= burst_cnt + 8'd1;
                if (release_gnt) begin
                    state    <= IDLE;
                    gnt_q    <= '0;
                    last_gnt <= g;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus a random phase, checked against a
// transaction-level model of the round-robin/burst rules.
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;

    logic wclk = 1'b0;
    logic wrst_n = 1'b0;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();
    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .bus(bus)
    );

    logic [NREQ-1:0] rv = '0;
    logic [NREQ-1:0] rl = '0;
    logic [7:0]      rd [NREQ];
    logic            wfull = 1'b0;

    assign bus.req_valid = rv;
    assign bus.req_last  = rl;
    assign bus.wfull     = wfull;
    always_comb begin
        bus.req_data = '0;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*DSIZE +: DSIZE] = rd[i];
    end

    bit          m_grant = 0;
    int          m_g = 0;
    int          m_last = NREQ - 1;
    int          m_burst = 0;
    logic [31:0] m_cnt = '0;
    bit          m_xfer;
    bit          preload_en = 0;
    logic [31:0] preload = '0;

    int checks = 0;
    int errors = 0;
    int winc_seen = 0;
    int plen [NREQ];
    int wcnt [NREQ];
    bit rnd = 0;
    logic [NREQ-1:0] prev_gnt = '0;
    logic [NREQ-1:0] gnt_log [$];
    logic [31:0]     cnt_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        int acc;
        bit done;
        #1;
        m_xfer = wrst_n && m_grant && rv[m_g] && !wfull;
        chk("winc", 32'(bus.winc), 32'(m_xfer));
        chk("req_ready", 32'(bus.req_ready), m_xfer ? 32'(1) << m_g : 32'd0);
        chk("wdata", 32'(bus.wdata), m_grant ? 32'(rd[m_g]) : 32'd0);
        chk("gnt", 32'(bus.gnt), m_grant ? 32'(1) << m_g : 32'd0);
        chk("busy", 32'(bus.busy), 32'(m_grant));
        chk("wr_count", bus.wr_count, m_cnt);
        if (bus.gnt != 0 && prev_gnt == 0) gnt_log.push_back(bus.gnt);
        prev_gnt = bus.gnt;
        if (bus.winc) winc_seen++;
        if (cnt_log.size() == 0 || cnt_log[$] != bus.wr_count) cnt_log.push_back(bus.wr_count);
        acc = m_xfer ? m_g : -1;
        @(posedge wclk);
        if (!wrst_n) begin
            m_grant = 0; m_last = NREQ - 1; m_cnt = '0; m_burst = 0;
        end else if (!m_grant) begin
            if (rv != 0) begin
                for (int k = 1; k <= NREQ; k++)
                    if (rv[(m_last + k) % NREQ]) begin
                        m_g = (m_last + k) % NREQ;
                        break;
                    end
                m_grant = 1;
                m_burst = 0;
            end
        end else begin
            done = (m_xfer && (rl[m_g] || m_burst == BURST - 1)) || !rv[m_g];
            if (m_xfer) begin
                m_burst++;
                m_cnt++;
            end
            if (done) begin
                m_grant = 0;
                m_last = m_g;
            end
        end
        if (preload_en) begin
            m_cnt = preload;
            preload_en = 0;
        end
        @(negedge wclk);
        for (int i = 0; i < NREQ; i++) begin
            if (acc == i) begin
                wcnt[i] = rl[i] ? 0 : wcnt[i] + 1;
                rd[i] = rnd ? 8'($urandom) : rd[i] + 8'd1;
                if (rnd) begin
                    rv[i] = ($urandom % 4) != 0;
                    rl[i] = ($urandom % 4) == 0;
                end else begin
                    rl[i] = plen[i] != 0 && wcnt[i] == plen[i] - 1;
                end
            end else if (rnd && !rv[i] && ($urandom % 3) == 0) begin
                rv[i] = 1'b1;
                rd[i] = 8'($urandom);
                rl[i] = ($urandom % 4) == 0;
            end
        end
        if (rnd) begin
            wfull = ($urandom % 4) == 0;
            wrst_n = ($urandom % 64) != 0;
        end
    endtask

    task automatic setup_pkt(input logic [NREQ-1:0] v);
        rv = v;
        for (int i = 0; i < NREQ; i++) begin
            wcnt[i] = 0;
            rl[i] = plen[i] == 1;
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            rd[i] = 8'(16 * i);
            plen[i] = 0;
            wcnt[i] = 0;
        end
        @(negedge wclk);
        cyc();
        wrst_n = 1'b1;

        // round-robin through all four with full bursts
        setup_pkt(4'b1111);
        gnt_log.delete();
        winc_seen = 0;
        repeat (20) cyc();
        chk("t1_wr_count", bus.wr_count, 32'd16);
        chk("t1_winc_pulses", 32'(winc_seen), 32'd16);
        repeat (2) cyc();
        chk("t1_grants", 32'(gnt_log.size()), 32'd5);
        for (int k = 0; k < gnt_log.size() && k < 5; k++)
            chk("t1_grant_order", 32'(gnt_log[k]), 32'(1) << (k % NREQ));
        rv = '0;
        repeat (2) cyc();

        // lone requester with 2-word packets keeps winning
        plen[2] = 2;
        setup_pkt(4'b0100);
        gnt_log.delete();
        winc_seen = 0;
        repeat (8) cyc();
        chk("t2_grants", 32'(gnt_log.size()), 32'd3);
        foreach (gnt_log[k]) chk("t2_grant_id", 32'(gnt_log[k]), 32'h4);
        chk("t2_winc_pulses", 32'(winc_seen), 32'd5);
        plen[2] = 0;
        setup_pkt('0);
        repeat (2) cyc();

        // wfull stall mid-burst
        setup_pkt(4'b0010);
        winc_seen = 0;
        repeat (3) cyc();
        wfull = 1'b1;
        repeat (5) cyc();
        chk("t3_stall_winc", 32'(winc_seen), 32'd2);
        chk("t3_stall_gnt", 32'(bus.gnt), 32'h2);
        wfull = 1'b0;
        repeat (3) cyc();
        chk("t3_total_words", 32'(winc_seen), 32'd4);
        rv = '0;
        repeat (2) cyc();

        // withdrawal releases the grant and rotates priority
        setup_pkt(4'b0001);
        repeat (2) cyc();
        rv = '0;
        cyc();
        chk("t4_released", 32'(bus.gnt), 32'h0);
        rv = 4'b0011;
        gnt_log.delete();
        repeat (2) cyc();
        chk("t4_grants", 32'(gnt_log.size()), 32'd1);
        if (gnt_log.size() > 0) chk("t4_next_grant", 32'(gnt_log[0]), 32'h2);
        rv = '0;
        repeat (2) cyc();

        // reset mid-burst
        setup_pkt(4'b1111);
        repeat (3) cyc();
        wrst_n = 1'b0;
        #1;
        chk("t5_winc_in_reset", 32'(bus.winc), 32'd0);
        chk("t5_ready_in_reset", 32'(bus.req_ready), 32'd0);
        cyc();
        wrst_n = 1'b1;
        chk("t5_gnt_after", 32'(bus.gnt), 32'h0);
        chk("t5_count_after", bus.wr_count, 32'd0);
        gnt_log.delete();
        repeat (2) cyc();
        if (gnt_log.size() > 0) chk("t5_first_grant", 32'(gnt_log[0]), 32'h1);
        else chk("t5_first_grant", 32'h0, 32'h1);
        rv = '0;
        repeat (2) cyc();

        // counter wrap from a preloaded value
        force dut.cnt_nxt = 32'hFFFF_FFFE;
        preload = 32'hFFFF_FFFE;
        preload_en = 1;
        cyc();
        release dut.cnt_nxt;
        plen[0] = 3;
        setup_pkt(4'b0001);
        cnt_log.delete();
        repeat (6) cyc();
        chk("t6_steps", 32'(cnt_log.size()), 32'd4);
        if (cnt_log.size() == 4) begin
            chk("t6_v0", cnt_log[0], 32'hFFFF_FFFE);
            chk("t6_v1", cnt_log[1], 32'hFFFF_FFFF);
            chk("t6_v2", cnt_log[2], 32'h0);
            chk("t6_v3", cnt_log[3], 32'h1);
        end
        plen[0] = 0;
        setup_pkt('0);
        repeat (2) cyc();

        // random traffic, backpressure and occasional resets
        rnd = 1;
        repeat (500) cyc();
        rnd = 0;
        wrst_n = 1'b1;
        wfull = 1'b0;
        rv = '0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
